// File: rtl/xup_nor_vector_checker_pkg.sv
// rtl/xup_nor_vector_checker_pkg.sv - shared state encoding and defaults for XUP vector checkers
//
// Purpose: state encoding and default parameter values shared by the XUP
// gate-library vector checkers and their settle timer.
// Contents:
//   xup_state_e  - checker FSM states (IDLE=0, DRIVE=1, CHECK=2, DONE=3)
//   DEF_SETTLE   - default settle time in clock cycles
//   DEF_ERR_W    - default error-counter width
package xup_nor_vector_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } xup_state_e;

  localparam int DEF_SETTLE = 2;
  localparam int DEF_ERR_W  = 16;

endpackage

// File: rtl/xup_nor_vector_checker_settle_timer.sv
// rtl/xup_nor_vector_checker_settle_timer.sv - settle-time counter with clear and terminal count
//
// Purpose: counts clock cycles while enabled and flags when SETTLE-1 is
// reached, so a checker can hold an operand pair for exactly SETTLE cycles.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   clear  in   synchronous restart of the count from zero
//   en     in   advance the count (stops at the terminal value)
//   tc     out  high while the count equals SETTLE-1
module xup_settle_timer
  import xup_nor_vector_checker_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] TERM = CW'(SETTLE - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/xup_nor_vector_checker.sv
// rtl/xup_nor_vector_checker.sv - sweep stimulus and checker for a SIZE-bit vector NOR stage
//
// Purpose: on start, sweeps {b,a} from 0 to NUM_VEC-1, holds each pair for
// SETTLE cycles, then compares y to ~(a|b) and tracks mismatches.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset (aborts any run)
//   start       in   one-cycle run request, honoured in IDLE or DONE only
//   a, b        out  registered operands to the gate stage
//   y           in   gate stage result, sampled only in CHECK
//   busy        out  high in DRIVE and CHECK
//   done        out  high in DONE until the next start or reset
//   pass        out  high in DONE when no mismatch was seen
//   err_count   out  saturating mismatch count
//   first_fail  out  sweep index of the first mismatch, 0 if none
module xup_nor_vector_checker
  import xup_nor_vector_checker_pkg::*;
#(
  parameter int     SIZE    = 8,
  parameter longint NUM_VEC = 256,
  parameter int     SETTLE  = DEF_SETTLE,
  parameter int     ERR_W   = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [SIZE-1:0]   a,
  output logic [SIZE-1:0]   b,
  input  logic [SIZE-1:0]   y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [2*SIZE-1:0] first_fail
);

  localparam int CW = 2 * SIZE;
  localparam logic [CW-1:0] LAST = CW'(NUM_VEC - 1);

  xup_state_e    state_q, state_d;
  logic [CW-1:0] cnt;
  logic          fail_seen;
  logic          accept;
  logic          timer_clear;
  logic          settle_tc;
  logic          at_last;
  logic          mismatch;

  xup_settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .en   (state_q == ST_DRIVE),
    .tc   (settle_tc)
  );

  // Operands are slices of the sweep register, so they change on the same
  // edge as cnt and stay put for the whole DRIVE/CHECK window.
  assign a = cnt[SIZE-1:0];
  assign b = cnt[CW-1:SIZE];

  assign at_last  = (cnt == LAST);
  assign mismatch = (y != ~(a | b));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    timer_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept      = 1'b1;
          timer_clear = 1'b1;
          state_d     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle_tc) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (at_last) begin
          state_d = ST_DONE;
        end else begin
          timer_clear = 1'b1;
          state_d     = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      cnt        <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else if (state_q == ST_CHECK) begin
      if (mismatch) begin
        if (err_count != {ERR_W{1'b1}}) begin
          err_count <= err_count + 1'b1;
        end
        if (!fail_seen) begin
          first_fail <= cnt;
          fail_seen  <= 1'b1;
        end
      end
      // The run ends at LAST, so the sweep counter never wraps.
      if (!at_last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
  assign done = (state_q == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_xup_nor_vector_checker.sv
// tb/tb_xup_nor_vector_checker.sv - directed bench for the XUP vector NOR checker
module tb_xup_nor_vector_checker;

  logic       clk;
  logic       reset;
  logic       start;
  int         mode;
  int         n_checks;
  int         n_fail;

  logic [1:0] a0, b0, y0;
  logic       busy0, done0, pass0;
  logic [15:0] err0;
  logic [3:0] ff0;

  logic [1:0] a1, b1, y1;
  logic       busy1, done1, pass1;
  logic [1:0] err1;
  logic [3:0] ff1;

  xup_nor_vector_checker #(
    .SIZE(2), .NUM_VEC(16), .SETTLE(2), .ERR_W(16)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start),
    .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(ff0)
  );

  xup_nor_vector_checker #(
    .SIZE(2), .NUM_VEC(16), .SETTLE(2), .ERR_W(2)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  // Gate models: 0 good NOR, 1 y[0] stuck-at-0, 2 y[1] stuck-at-1.
  always_comb begin
    y0 = ~(a0 | b0);
    case (mode)
      1: y0 = ~(a0 | b0) & 2'b10;
      2: y0 = ~(a0 | b0) | 2'b10;
      default: y0 = ~(a0 | b0);
    endcase
  end

  // Always-wrong model: every bit inverted relative to NOR.
  assign y1 = a1 | b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input bit chk_sweep, input bit inject, output int lat);
    int cyc;
    lat = -1;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy0), 1);
    check("done_cleared", 32'(done0), 0);
    check("err_cleared", 32'(err0), 0);
    check("err1_cleared", 32'(err1), 0);
    while (lat < 0 && cyc <= 200) begin
      if (done0) begin
        lat = cyc;
      end else begin
        if (chk_sweep && cyc < 48) check("sweep_ab", 32'({b0, a0}), cyc / 3);
        if (inject && (cyc == 3 || cyc == 10)) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    check("done_latency", lat, 48);
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    mode     = 0;
    repeat (3) @(negedge clk);
    check("rst_ab", 32'({b0, a0}), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_pass", 32'(pass0), 0);
    check("rst_err", 32'(err0), 0);
    check("rst_ff", 32'(ff0), 0);
    reset = 1'b0;

    // Clean sweep with full operand trace.
    mode = 0;
    run_sweep(1'b1, 1'b0, lat);
    check("clean_pass", 32'(pass0), 1);
    check("clean_err", 32'(err0), 0);
    check("clean_ff", 32'(ff0), 0);
    check("clean_busy", 32'(busy0), 0);
    check("clean_ab_hold", 32'({b0, a0}), 15);
    check("sat_done", 32'(done1), 1);
    check("sat_err", 32'(err1), 3);
    check("sat_pass", 32'(pass1), 0);
    check("sat_ff", 32'(ff1), 0);

    // y[0] stuck-at-0: mismatches at 0,2,8,10.
    mode = 1;
    run_sweep(1'b0, 1'b0, lat);
    check("sa0_err", 32'(err0), 4);
    check("sa0_ff", 32'(ff0), 0);
    check("sa0_pass", 32'(pass0), 0);

    // y[1] stuck-at-1: 12 mismatches, first at index 2.
    mode = 2;
    run_sweep(1'b0, 1'b0, lat);
    check("sa1_err", 32'(err0), 12);
    check("sa1_ff", 32'(ff0), 2);
    check("sa1_pass", 32'(pass0), 0);

    // Extra starts while busy must be ignored.
    mode = 0;
    run_sweep(1'b0, 1'b1, lat);
    check("ign_pass", 32'(pass0), 1);
    check("ign_err", 32'(err0), 0);
    check("ign_ff", 32'(ff0), 0);

    // Reset during DRIVE of pair 5.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_ab", 32'({b0, a0}), 5);
    check("mid_busy", 32'(busy0), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ab", 32'({b0, a0}), 0);
    check("midrst_busy", 32'(busy0), 0);
    check("midrst_done", 32'(done0), 0);
    check("midrst_pass", 32'(pass0), 0);
    check("midrst_err", 32'(err0), 0);
    check("midrst_ff", 32'(ff0), 0);
    @(negedge clk);
    check("midrst_idle", 32'(busy0), 0);
    check("midrst_idle_done", 32'(done0), 0);
    run_sweep(1'b0, 1'b0, lat);
    check("post_rst_pass", 32'(pass0), 1);
    check("post_rst_err", 32'(err0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
